// File: rtl/line_mem_responder.sv
// line_mem_responder: memory-side slave for the cache line interface.
// Accepts one line read or write at a time and answers after a fixed,
// programmable latency with a single-cycle mem_ready_o pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for mem_read_i / mem_write_i; request latched here
// WAIT  | latency down-counter running; inputs ignored
// RESP  | mem_ready_o high for this one cycle; write commits on exit
module line_mem_responder #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ready_o,
    output logic              err_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    op_wr;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       mem [0:DEPTH-1];

    logic [DEPTH_LOG2-1:0]   addr_idx;
    logic                    req;

    // Upper address bits alias onto the stored lines by design.
    logic                    unused_addr_hi;

    assign addr_idx       = mem_addr_i[DEPTH_LOG2-1:0];
    assign req            = mem_read_i | mem_write_i;
    assign unused_addr_hi = ^mem_addr_i[ADDR_W-1:DEPTH_LOG2];

    // Request sequencing FSM; read data is captured on the edge entering RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_wr       <= 1'b0;
            idx         <= '0;
            wdata_q     <= '0;
            mem_ready_o <= 1'b0;
            mem_rdata_o <= '0;
            err_o       <= 1'b0;
        end else begin
            mem_ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        // Write wins when both are asserted.
                        op_wr   <= mem_write_i;
                        idx     <= addr_idx;
                        wdata_q <= mem_wdata_i;
                        cnt     <= CNT_W'(LATENCY - 1);
                        if (mem_read_i && mem_write_i) begin
                            err_o <= 1'b1;
                        end
                        if (LATENCY == 1) begin
                            state       <= RESP;
                            mem_ready_o <= 1'b1;
                            if (!mem_write_i) begin
                                mem_rdata_o <= mem[addr_idx];
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state       <= RESP;
                        mem_ready_o <= 1'b1;
                        if (!op_wr) begin
                            mem_rdata_o <= mem[idx];
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line storage is deliberately not reset; a reset before RESP drops the write.
    always_ff @(posedge clk) begin
        if (state == RESP && op_wr) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule
